dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter in front of the single-port data memory. It shares the memory between the pipeline MEM stage (core port) and a debug/loader port (dbg port). It issues one word access per cycle and returns read data registered one cycle later. It sits between the core/debug logic and the data memory's combinational-read, synchronous-write port.

## Interface
Parameters:
- STARVE_MAX, 3: consecutive cycles the dbg port may be refused before it is forced to win (1..15).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- c_req  in  1  core request valid
- c_we  in  1  core write (1) / read (0)
- c_addr  in  32  core byte address
- c_wdata  in  32  core write data
- c_gnt  out  1  core request accepted this cycle
- c_rvalid  out  1  core read data valid
- c_rdata  out  32  core read data
- d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata: same as the c_* ports, for the dbg port
- m_addr  out  32  memory byte address
- m_dataW  out  32  memory write data
- m_MemRW  out  1  memory write strobe (1 write, 0 read)
- m_dataR  in  32  memory combinational read data
- busy  out  1  a request was granted this cycle

## Operation
- **Per cycle:** at most one of c_gnt/d_gnt is 1. The granted port's addr, wdata and we drive m_addr, m_dataW and m_MemRW combinationally.
- **No grant:** m_addr=0, m_dataW=0, m_MemRW=0.
- **Default policy: fixed priority, core first.**
  - Starve counter `st_cnt` (4 bits) increments each cycle with d_req=1 and d_gnt=0, saturating at STARVE_MAX.
  - When st_cnt==STARVE_MAX and d_req=1, dbg wins over core and st_cnt clears.
  - st_cnt also clears on any d_gnt, and whenever d_req=0.
- **Read grant:** m_dataR is captured on the rising edge into that port's rdata register. That port's rvalid is 1 in the following cycle only.
- **Write grant:** the memory writes on the same edge. No rvalid is produced.
- **Rdata hold:** c_rdata and d_rdata hold their last value until the next granted read of the same port.
- **Misaligned or out-of-range address:** passed through and granted normally. The memory ignores the write or returns 0, and the arbiter returns that 0 with rvalid.
- **Back-to-back:** a port may be granted every cycle. rvalid pulses back-to-back accordingly.

## Timing
- c_gnt and d_gnt are combinational from c_req, d_req, st_cnt and rr_last. There is no combinational path from m_dataR to any output.
- A requester holds req, we, addr and wdata stable until it sees gnt=1 at a rising edge. That edge completes the transfer.
- Read latency: 1 cycle from the grant edge to rvalid.
- Reset values while rst_n=0 (asynchronous):
  - c_rvalid=0, d_rvalid=0, c_rdata=0, d_rdata=0
  - st_cnt=0, rr_last=core
- Gnt and m_* outputs are forced to 0 while rst_n=0.
- Reset asserted mid-read: the pending rvalid is discarded. No rvalid appears after reset release.
- Both ports requesting with st_cnt below STARVE_MAX: core is granted. The dbg port waits at most STARVE_MAX+1 cycles.

## Configuration
- **DMEM_ARB_RR_EN defined:** round-robin replaces the fixed-priority and starve logic.
  - A 1-bit rr_last register records the last granted port.
  - On contention, the port not equal to rr_last wins.
  - A single requester always wins. rr_last updates on every grant.
  - st_cnt is absent.
- **DMEM_ARB_RR_EN undefined:** fixed priority with starvation limit, as in Operation.

## Test plan
- **Reset:** hold rst_n=0 with c_req=1 -> c_gnt=0, m_MemRW=0, both rvalid=0 and both rdata=0. Release -> core granted the same cycle.
- **Single core write then read:**
  - c_we=1, c_addr=0x10, c_wdata=0xDEADBEEF granted -> m_MemRW=1 that cycle.
  - Next c_we=0, c_addr=0x10 -> c_rvalid=1 one cycle later with c_rdata=0xDEADBEEF.
- **Contention, fixed priority, STARVE_MAX=3:** c_req and d_req held high continuously -> grant pattern c,c,c,d repeating. d_rvalid follows each d grant by 1 cycle.
- **Contention with DMEM_ARB_RR_EN:** both requesting from reset -> grants alternate d,c,d,c.
- **Read-data routing:** core read of 0x0 (memory 0x11111111) then dbg read of 0x4 (memory 0x22222222) on consecutive cycles:
  - c_rdata=0x11111111 and d_rdata=0x22222222.
  - Each rvalid asserts only on its own port.
  - c_rdata still reads 0x11111111 afterwards.
- **Reset mid-read:** grant a dbg read, then assert rst_n=0 before the next edge -> d_rvalid stays 0 and d_rdata=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core MEM stage
// and the debug/loader port. One access per cycle. Read data is registered
// into the granted port's rdata one cycle after the grant.
// Optional build macro DMEM_ARB_RR_EN: round-robin replaces the fixed
// core-first priority and its starvation limit.
module dmem_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] m_addr,
  output logic [31:0] m_dataW,
  output logic        m_MemRW,
  input  logic [31:0] m_dataR,
  output logic        busy
);

  logic c_win, d_win;

`ifdef DMEM_ARB_RR_EN
  // last granted port: 0 = core, 1 = dbg
  logic rr_last;

  // contention goes to the port that did not win last; a lone requester wins
  always_comb begin
    c_win = c_req;
    d_win = d_req;
    if (c_req && d_req) begin
      c_win = rr_last;
      d_win = !rr_last;
    end
  end

  // remember which port was granted most recently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rr_last <= 1'b0;
    else if (c_gnt) rr_last <= 1'b0;
    else if (d_gnt) rr_last <= 1'b1;
  end
`else
  localparam logic [3:0] ST_MAX = 4'(STARVE_MAX);
  logic [3:0] st_cnt;

  // core first, unless dbg has been refused for STARVE_MAX cycles in a row
  always_comb begin
    d_win = d_req && (!c_req || (st_cnt == ST_MAX));
    c_win = c_req && !d_win;
  end

  // count consecutive refused dbg cycles, saturating; clear on grant or idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                st_cnt <= 4'd0;
    else if (!d_req || d_gnt)  st_cnt <= 4'd0;
    else if (st_cnt != ST_MAX) st_cnt <= st_cnt + 4'd1;
  end
`endif

  // grants are suppressed while reset is held so the memory never sees a strobe
  always_comb begin
    c_gnt = rst_n && c_win;
    d_gnt = rst_n && d_win;
    busy  = c_gnt || d_gnt;
  end

  // steer the granted port onto the memory bus; idle bus is all zero
  always_comb begin
    m_addr  = 32'd0;
    m_dataW = 32'd0;
    m_MemRW = 1'b0;
    if (c_gnt) begin
      m_addr  = c_addr;
      m_dataW = c_wdata;
      m_MemRW = c_we;
    end else if (d_gnt) begin
      m_addr  = d_addr;
      m_dataW = d_wdata;
      m_MemRW = d_we;
    end
  end

  // capture read data for the port that won a read; rdata holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      c_rdata  <= 32'd0;
      d_rdata  <= 32'd0;
    end else begin
      c_rvalid <= c_gnt && !c_we;
      d_rvalid <= d_gnt && !d_we;
      if (c_gnt && !c_we) c_rdata <= m_dataR;
      if (d_gnt && !d_we) d_rdata <= m_dataR;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table plus hand sequences for reset,
// contention and reset during a pending read. A small 64-word memory with
// combinational read answers the arbiter; misaligned or out-of-range
// accesses read 0 and ignore writes.
module tb_dmem_arbiter;

  logic        clk, rst_n;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
  logic [31:0] c_rdata, d_rdata;
  logic [31:0] m_addr, m_dataW, m_dataR;
  logic        m_MemRW, busy;

  int errors = 0;
  int checks = 0;

  dmem_arbiter #(.STARVE_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_dataW(m_dataW), .m_MemRW(m_MemRW),
    .m_dataR(m_dataR), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory: preloaded while reset is held, synchronous write
  logic [31:0] mem [0:63];
  logic        m_ok;
  always_comb begin
    m_ok    = (m_addr[1:0] == 2'b00) && (m_addr < 32'd256);
    m_dataR = m_ok ? mem[m_addr[7:2]] : 32'd0;
  end
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= 32'h11111111;
      mem[1] <= 32'h22222222;
    end else if (m_MemRW && m_ok) begin
      mem[m_addr[7:2]] <= m_dataW;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        c_req, c_we;
    logic [31:0] c_addr, c_wdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic        e_cg, e_dg, e_we;
    logic [31:0] e_addr, e_wdata;
    logic        e_cv;
    logic [31:0] e_crd;
    logic        e_dv;
    logic [31:0] e_drd;
  } vec_t;

  vec_t vec [13];
  logic exp_d [8];

  initial begin
    //           c_req c_we c_addr  c_wdata   d_req d_we d_addr d_wdata  | cg dg we m_addr  m_dataW  cv c_rdata  dv d_rdata
    vec[0]  = '{1'b1,1'b0,32'h10,  32'h0,     1'b0,1'b0,32'h0, 32'h0,       1'b1,1'b0,1'b0,32'h10,  32'h0,       1'b0,32'h0,        1'b0,32'h0};
    vec[1]  = '{1'b1,1'b0,32'h0,   32'h0,     1'b0,1'b0,32'h0, 32'h0,       1'b1,1'b0,1'b0,32'h0,   32'h0,       1'b1,32'hDEADBEEF, 1'b0,32'h0};
    vec[2]  = '{1'b0,1'b0,32'h0,   32'h0,     1'b1,1'b0,32'h4, 32'h0,       1'b0,1'b1,1'b0,32'h4,   32'h0,       1'b1,32'h11111111, 1'b0,32'h0};
    vec[3]  = '{1'b0,1'b0,32'h0,   32'h0,     1'b0,1'b0,32'h0, 32'h0,       1'b0,1'b0,1'b0,32'h0,   32'h0,       1'b0,32'h11111111, 1'b1,32'h22222222};
    vec[4]  = '{1'b0,1'b0,32'h0,   32'h0,     1'b1,1'b1,32'h8, 32'hCAFEF00D,1'b0,1'b1,1'b1,32'h8,   32'hCAFEF00D,1'b0,32'h11111111, 1'b0,32'h22222222};
    vec[5]  = '{1'b1,1'b0,32'h8,   32'h0,     1'b0,1'b0,32'h0, 32'h0,       1'b1,1'b0,1'b0,32'h8,   32'h0,       1'b0,32'h11111111, 1'b0,32'h22222222};
    vec[6]  = '{1'b1,1'b0,32'h3,   32'h0,     1'b0,1'b0,32'h0, 32'h0,       1'b1,1'b0,1'b0,32'h3,   32'h0,       1'b1,32'hCAFEF00D, 1'b0,32'h22222222};
    vec[7]  = '{1'b1,1'b0,32'h1000,32'h0,     1'b0,1'b0,32'h0, 32'h0,       1'b1,1'b0,1'b0,32'h1000,32'h0,       1'b1,32'h0,        1'b0,32'h22222222};
    vec[8]  = '{1'b1,1'b0,32'h0,   32'h0,     1'b0,1'b0,32'h0, 32'h0,       1'b1,1'b0,1'b0,32'h0,   32'h0,       1'b1,32'h0,        1'b0,32'h22222222};
    vec[9]  = '{1'b0,1'b0,32'h0,   32'h0,     1'b0,1'b0,32'h0, 32'h0,       1'b0,1'b0,1'b0,32'h0,   32'h0,       1'b1,32'h11111111, 1'b0,32'h22222222};
    vec[10] = '{1'b1,1'b1,32'h3,   32'h55,    1'b0,1'b0,32'h0, 32'h0,       1'b1,1'b0,1'b1,32'h3,   32'h55,      1'b0,32'h11111111, 1'b0,32'h22222222};
    vec[11] = '{1'b1,1'b0,32'h0,   32'h0,     1'b0,1'b0,32'h0, 32'h0,       1'b1,1'b0,1'b0,32'h0,   32'h0,       1'b0,32'h11111111, 1'b0,32'h22222222};
    vec[12] = '{1'b0,1'b0,32'h0,   32'h0,     1'b0,1'b0,32'h0, 32'h0,       1'b0,1'b0,1'b0,32'h0,   32'h0,       1'b1,32'h11111111, 1'b0,32'h22222222};

`ifdef DMEM_ARB_RR_EN
    exp_d = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0};
`else
    exp_d = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1};
`endif

    // reset held with a pending core write request
    rst_n = 1'b0;
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h10; c_wdata = 32'hDEADBEEF;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0;  d_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst c_gnt",    {31'd0, c_gnt},    32'd0);
    chk("rst d_gnt",    {31'd0, d_gnt},    32'd0);
    chk("rst m_MemRW",  {31'd0, m_MemRW},  32'd0);
    chk("rst m_addr",   m_addr,            32'd0);
    chk("rst busy",     {31'd0, busy},     32'd0);
    chk("rst c_rvalid", {31'd0, c_rvalid}, 32'd0);
    chk("rst d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("rst c_rdata",  c_rdata,           32'd0);
    chk("rst d_rdata",  d_rdata,           32'd0);

    // release: core write granted in the same cycle
    rst_n = 1'b1;
    #1;
    chk("rel c_gnt",   {31'd0, c_gnt},   32'd1);
    chk("rel m_MemRW", {31'd0, m_MemRW}, 32'd1);
    chk("rel m_addr",  m_addr,           32'h10);
    chk("rel m_dataW", m_dataW,          32'hDEADBEEF);

    // vector table: one vector per cycle, registered outputs reflect the previous vector
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      c_req = vec[i].c_req; c_we = vec[i].c_we; c_addr = vec[i].c_addr; c_wdata = vec[i].c_wdata;
      d_req = vec[i].d_req; d_we = vec[i].d_we; d_addr = vec[i].d_addr; d_wdata = vec[i].d_wdata;
      @(negedge clk);
      chk($sformatf("v%0d c_gnt", i),    {31'd0, c_gnt},    {31'd0, vec[i].e_cg});
      chk($sformatf("v%0d d_gnt", i),    {31'd0, d_gnt},    {31'd0, vec[i].e_dg});
      chk($sformatf("v%0d busy", i),     {31'd0, busy},     {31'd0, vec[i].e_cg | vec[i].e_dg});
      chk($sformatf("v%0d m_MemRW", i),  {31'd0, m_MemRW},  {31'd0, vec[i].e_we});
      chk($sformatf("v%0d m_addr", i),   m_addr,            vec[i].e_addr);
      chk($sformatf("v%0d m_dataW", i),  m_dataW,           vec[i].e_wdata);
      chk($sformatf("v%0d c_rvalid", i), {31'd0, c_rvalid}, {31'd0, vec[i].e_cv});
      chk($sformatf("v%0d c_rdata", i),  c_rdata,           vec[i].e_crd);
      chk($sformatf("v%0d d_rvalid", i), {31'd0, d_rvalid}, {31'd0, vec[i].e_dv});
      chk($sformatf("v%0d d_rdata", i),  d_rdata,           vec[i].e_drd);
    end

    // contention from a fresh reset: both ports read continuously
    @(posedge clk); #1;
    rst_n = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("arb%0d c_gnt", k), {31'd0, c_gnt}, {31'd0, !exp_d[k]});
      chk($sformatf("arb%0d d_gnt", k), {31'd0, d_gnt}, {31'd0, exp_d[k]});
      @(posedge clk); #1;
      chk($sformatf("arb%0d d_rvalid", k), {31'd0, d_rvalid}, {31'd0, exp_d[k]});
      chk($sformatf("arb%0d c_rvalid", k), {31'd0, c_rvalid}, {31'd0, !exp_d[k]});
      if (exp_d[k]) chk($sformatf("arb%0d d_rdata", k), d_rdata, 32'h22222222);
      else          chk($sformatf("arb%0d c_rdata", k), c_rdata, 32'h11111111);
      @(negedge clk);
    end

    // reset asserted while a dbg read is pending
    c_req = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
    #1;
    chk("mid d_gnt", {31'd0, d_gnt}, 32'd1);
    #2;
    rst_n = 1'b0;
    d_req = 1'b0;
    @(posedge clk); #1;
    chk("mid d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("mid d_rdata",  d_rdata,           32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("post d_rdata",  d_rdata,           32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
